// File: rtl/pdm_cic_pkg.sv
// Shared constants and helpers for the PDM microphone CIC decimator.
package pdm_cic_pkg;

    localparam int MAX_STAGES  = 6;
    localparam int MIN_CLK_DIV = 8;
    localparam int SAT_W       = 64;

    // Accumulator width needed so the CIC gain DEC_RATE^N never overflows,
    // plus a sign bit and one bit of headroom for the +/-1 input mapping.
    function automatic int acc_width(input int n_stages, input int dec_rate);
        return n_stages * $clog2(dec_rate) + 2;
    endfunction

    // Align the accumulator so full scale lands on the output MSB, then clamp
    // to the signed output range. The caller truncates the result to out_w.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] value,
        input int                      acc_w,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] maxVal;
        logic signed [SAT_W-1:0] minVal;
        one = 1;
        if (acc_w - 1 > out_w) begin
            shifted = value >>> (acc_w - 1 - out_w);
        end else begin
            shifted = value <<< (out_w - acc_w + 1);
        end
        maxVal = (one <<< (out_w - 1)) - one;
        minVal = -maxVal - one;
        if (shifted > maxVal) begin
            return maxVal;
        end else if (shifted < minVal) begin
            return minVal;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/pdm_cic_decimator_clkgen.sv
// Microphone bit clock divider, M_DATA synchronizer and bit strobe.
module pdm_clk_gen
    import pdm_cic_pkg::*;
#(
    parameter int CLK_DIV = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_mData,
    output logic o_mClk,
    output logic o_strobe,
    output logic o_bit
);

    localparam int               DIV      = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
    localparam int               CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_mClk;
    logic [1:0]       r_sync;

    assign w_cntNext = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);

    // Divider counter and registered M_CLK, low in the first half-period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_mClk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_mClk <= 1'b0;
        end else begin
            r_cnt  <= w_cntNext;
            r_mClk <= (w_cntNext >= CNT_HALF);
        end
    end

    // Two-flop synchronizer for the asynchronous microphone data line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_mData};
        end
    end

    assign o_mClk   = r_mClk;
    assign o_strobe = i_en && (r_cnt == CNT_LAST);
    assign o_bit    = r_sync[1];

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: N-stage CIC decimator with valid/ready output.
module pdm_cic_decimator
    import pdm_cic_pkg::*;
#(
    parameter int   CLK_DIV  = 32,
    parameter int   DEC_RATE = 64,
    parameter int   N_STAGES = 4,
    parameter int   OUT_W    = 16,
    parameter logic LR_SEL   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    output logic             M_CLK,
    input  logic             M_DATA,
    output logic             M_LRSEL,
    output logic [OUT_W-1:0] pcm_data,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun
);

    localparam int                ACC_W     = acc_width(N_STAGES, DEC_RATE);
    localparam int                DCNT_W    = $clog2(DEC_RATE);
    localparam int                WARM_W    = $clog2(MAX_STAGES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEC_RATE - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(N_STAGES);

    logic                    w_strobe;
    logic                    w_bit;
    logic                    w_decim;
    logic                    w_result;
    logic                    w_newSample;
    logic signed [ACC_W-1:0] w_inVal;
    logic signed [ACC_W-1:0] w_integLast;
    logic signed [ACC_W-1:0] w_combLast;
    logic [DCNT_W-1:0]       r_dcnt;
    logic [N_STAGES:0]       r_stageVld;
    logic [WARM_W-1:0]       r_warm;
    logic [OUT_W-1:0]        r_pcmData;
    logic                    r_pcmValid;
    logic                    r_overrun;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkGen (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_en     (en),
        .i_mData  (M_DATA),
        .o_mClk   (M_CLK),
        .o_strobe (w_strobe),
        .o_bit    (w_bit)
    );

    assign w_inVal     = {{(ACC_W-1){~w_bit}}, 1'b1};
    assign w_decim     = w_strobe && (r_dcnt == DCNT_LAST);
    assign w_result    = r_stageVld[N_STAGES];
    assign w_newSample = w_result && (r_warm == WARM_DONE);

    for (genvar g = 0; g < N_STAGES; g++) begin : g_integ
        logic signed [ACC_W-1:0] r_acc;
        logic signed [ACC_W-1:0] w_in;
        if (g == 0) begin : g_first
            assign w_in = w_inVal;
        end else begin : g_next
            assign w_in = g_integ[g-1].r_acc;
        end

        // Integrator stage at the bit rate; wraps freely, the combs undo it.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_acc <= '0;
            end else if (!en) begin
                r_acc <= '0;
            end else if (w_strobe) begin
                r_acc <= r_acc + w_in;
            end
        end
    end

    assign w_integLast = g_integ[N_STAGES-1].r_acc;

    for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
        logic signed [ACC_W-1:0] r_out;
        logic signed [ACC_W-1:0] r_dly;
        logic signed [ACC_W-1:0] w_in;
        if (g == 0) begin : g_first
            assign w_in = w_integLast;
        end else begin : g_next
            assign w_in = g_comb[g-1].r_out;
        end

        // Comb stage fires once per decimated sample, one CLK after its input.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_out <= '0;
                r_dly <= '0;
            end else if (!en) begin
                r_out <= '0;
                r_dly <= '0;
            end else if (r_stageVld[g]) begin
                r_out <= w_in - r_dly;
                r_dly <= w_in;
            end
        end
    end

    assign w_combLast = g_comb[N_STAGES-1].r_out;

    // Decimation counter and the token that walks down the comb pipeline.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dcnt     <= '0;
            r_stageVld <= '0;
        end else if (!en) begin
            r_dcnt     <= '0;
            r_stageVld <= '0;
        end else begin
            if (w_strobe) begin
                r_dcnt <= r_dcnt + DCNT_W'(1);
            end
            r_stageVld <= {r_stageVld[N_STAGES-1:0], w_decim};
        end
    end

    // Drop the first N_STAGES results while the comb delays fill with real history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_warm <= '0;
        end else if (!en) begin
            r_warm <= '0;
        end else if (w_result && (r_warm != WARM_DONE)) begin
            r_warm <= r_warm + WARM_W'(1);
        end
    end

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pcmData  <= '0;
            r_pcmValid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (!en) begin
            r_pcmData  <= '0;
            r_pcmValid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_newSample) begin
            r_pcmData  <= OUT_W'(sat_shift(SAT_W'(w_combLast), ACC_W, OUT_W));
            r_pcmValid <= 1'b1;
            if (r_pcmValid && !pcm_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_pcmValid && pcm_ready) begin
            r_pcmValid <= 1'b0;
        end
    end

    assign pcm_data  = r_pcmData;
    assign pcm_valid = r_pcmValid;
    assign overrun   = r_overrun;
    assign M_LRSEL   = LR_SEL;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed self-checking bench for pdm_cic_decimator at default parameters.
`timescale 1ns/1ps
module tb_pdm_cic_decimator;

    localparam int FIRST_LAT  = 10244;
    localparam int OUT_PERIOD = 2048;

    logic        clock;
    logic        resetN;
    logic        en;
    logic        mClk;
    logic        mData;
    logic        mLrsel;
    logic [15:0] pcmData;
    logic        pcmValid;
    logic        pcmReady;
    logic        overrun;

    int   checks;
    int   errors;
    int   edgeIdx;
    int   mclkHigh;
    int   mclkRise;
    int   firstRise;
    int   secondRise;
    int   lrselBad;
    int   idleHigh;
    bit   toggleMode;
    logic prevMclk;

    pdm_cic_decimator dut (
        .CLK       (clock),
        .RST_N     (resetN),
        .en        (en),
        .M_CLK     (mClk),
        .M_DATA    (mData),
        .M_LRSEL   (mLrsel),
        .pcm_data  (pcmData),
        .pcm_valid (pcmValid),
        .pcm_ready (pcmReady),
        .overrun   (overrun)
    );

    // 100 MHz system clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one CLK edge, sample just after it, and gather M_CLK statistics.
    task automatic applyStimulus();
        logic rise;
        @(posedge clock);
        #1;
        edgeIdx++;
        rise = mClk && !prevMclk;
        if (edgeIdx >= 0 && edgeIdx < 64) begin
            if (mClk) mclkHigh++;
            if (rise) begin
                mclkRise++;
                if (firstRise < 0) firstRise = edgeIdx;
                else if (secondRise < 0) secondRise = edgeIdx;
            end
        end
        if (mLrsel !== 1'b0) lrselBad++;
        if (toggleMode && rise) mData = ~mData;
        prevMclk = mClk;
    endtask

    task automatic startCapture();
        en         = 1'b1;
        edgeIdx    = -1;
        prevMclk   = 1'b0;
        mclkHigh   = 0;
        mclkRise   = 0;
        firstRise  = -1;
        secondRise = -1;
    endtask

    task automatic stopCapture();
        en = 1'b0;
        repeat (3) applyStimulus();
    endtask

    task automatic runUntilValid(input int limit);
        int n;
        n = 0;
        while (pcmValid !== 1'b1 && n < limit) begin
            applyStimulus();
            n++;
        end
    endtask

    task automatic runTo(input int target);
        while (edgeIdx < target) applyStimulus();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        lrselBad   = 0;
        edgeIdx    = -1000;
        prevMclk   = 1'b0;
        toggleMode = 1'b0;
        resetN     = 1'b0;
        en         = 1'b0;
        mData      = 1'b1;
        pcmReady   = 1'b1;

        repeat (5) @(posedge clock);
        #1;
        checkOutput("rst_mclk", mClk, 1'b0);
        checkOutput("rst_valid", pcmValid, 1'b0);
        checkOutput("rst_data", pcmData, 16'h0000);
        checkOutput("rst_overrun", overrun, 1'b0);
        checkOutput("rst_lrsel", mLrsel, 1'b0);

        resetN   = 1'b1;
        idleHigh = 0;
        repeat (40) begin
            applyStimulus();
            if (mClk) idleHigh++;
        end
        checkOutput("idle_mclk_high", idleHigh, 0);

        // Constant 1: full-scale positive, latency and output cadence.
        startCapture();
        runUntilValid(FIRST_LAT + 100);
        checkOutput("one_valid", pcmValid, 1'b1);
        checkOutput("one_latency", edgeIdx, FIRST_LAT);
        checkOutput("one_data", pcmData, 16'h7FFF);
        checkOutput("one_overrun", overrun, 1'b0);
        checkOutput("mclk_high_cnt", mclkHigh, 32);
        checkOutput("mclk_rise_cnt", mclkRise, 2);
        checkOutput("mclk_period", secondRise - firstRise, 32);
        applyStimulus();
        checkOutput("one_pulse_width", pcmValid, 1'b0);
        runUntilValid(OUT_PERIOD + 10);
        checkOutput("one_valid2", pcmValid, 1'b1);
        checkOutput("one_period", edgeIdx, FIRST_LAT + OUT_PERIOD);
        checkOutput("one_data2", pcmData, 16'h7FFF);
        stopCapture();
        checkOutput("en_low_mclk", mClk, 1'b0);

        // Constant 0: full-scale negative, nothing leaks during warm-up.
        mData = 1'b0;
        startCapture();
        runUntilValid(FIRST_LAT + 100);
        checkOutput("zero_latency", edgeIdx, FIRST_LAT);
        checkOutput("zero_data", pcmData, 16'h8000);
        stopCapture();

        // Alternating bits: zero mean, zero output.
        mData      = 1'b1;
        toggleMode = 1'b1;
        startCapture();
        runUntilValid(FIRST_LAT + 100);
        checkOutput("alt_latency", edgeIdx, FIRST_LAT);
        checkOutput("alt_data", pcmData, 16'h0000);
        applyStimulus();
        runUntilValid(OUT_PERIOD + 10);
        checkOutput("alt_data2", pcmData, 16'h0000);
        stopCapture();
        toggleMode = 1'b0;

        // Stalled consumer: overwrite, sticky overrun, accept, clear on en low.
        mData    = 1'b1;
        pcmReady = 1'b0;
        repeat (3) applyStimulus();
        startCapture();
        runUntilValid(FIRST_LAT + 100);
        checkOutput("ovr_latency", edgeIdx, FIRST_LAT);
        checkOutput("ovr_first_data", pcmData, 16'h7FFF);
        checkOutput("ovr_first_flag", overrun, 1'b0);
        mData = 1'b0;
        runTo(FIRST_LAT + OUT_PERIOD - 1);
        checkOutput("ovr_before_flag", overrun, 1'b0);
        checkOutput("ovr_before_valid", pcmValid, 1'b1);
        applyStimulus();
        checkOutput("ovr_second_flag", overrun, 1'b1);
        checkOutput("ovr_second_valid", pcmValid, 1'b1);
        runTo(FIRST_LAT + 5 * OUT_PERIOD);
        checkOutput("ovr_latest_data", pcmData, 16'h8000);
        checkOutput("ovr_latest_valid", pcmValid, 1'b1);
        pcmReady = 1'b1;
        applyStimulus();
        pcmReady = 1'b0;
        checkOutput("ovr_accept_valid", pcmValid, 1'b0);
        checkOutput("ovr_accept_flag", overrun, 1'b1);
        en = 1'b0;
        applyStimulus();
        checkOutput("ovr_clear_flag", overrun, 1'b0);
        checkOutput("ovr_clear_mclk", mClk, 1'b0);

        // Asynchronous reset mid-frame restarts the warm-up.
        mData    = 1'b1;
        pcmReady = 1'b1;
        startCapture();
        runTo(6000);
        checkOutput("arst_mclk_before", mClk, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("arst_mclk", mClk, 1'b0);
        checkOutput("arst_valid", pcmValid, 1'b0);
        checkOutput("arst_data", pcmData, 16'h0000);
        #2;
        resetN   = 1'b1;
        edgeIdx  = -1;
        prevMclk = 1'b0;
        runUntilValid(FIRST_LAT + 100);
        checkOutput("arst_latency", edgeIdx, FIRST_LAT);
        checkOutput("arst_data2", pcmData, 16'h7FFF);

        checkOutput("lrsel_const", lrselBad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
